// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
// One operation is in flight at a time, moving through IDLE -> EXEC -> RESP.
// The optional macro ALU_ARB_RR_EN selects round-robin arbitration.
// Without it, requester 0 always wins a tie.
// The IDLE_ZERO parameter chooses whether the ALU operand/control outputs
// are forced to zero outside EXEC, or keep showing the last latched operation.
module alu_share_arbiter #(
  parameter int unsigned IDLE_ZERO = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [1:0]   req0_sel,
  input  logic [127:0] req0_src,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [31:0]  rsp0_result,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [1:0]   req1_sel,
  input  logic [127:0] req1_src,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [31:0]  rsp1_result,
  output logic [3:0]   alu_op,
  output logic         d1_sel,
  output logic         d2_sel,
  output logic [31:0]  rs1_data,
  output logic [31:0]  rs2_data,
  output logic [31:0]  immediate,
  output logic [31:0]  pc,
  input  logic [31:0]  alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q;
  logic [1:0]     sel_q;
  logic [127:0]   src_q;
  logic           owner_q;
  logic [31:0]    result_q;
  logic           grant0, grant1, accept, winner, handshake, drive_alu;

`ifdef ALU_ARB_RR_EN
  logic           ptr_q;   // preferred requester when both are valid
`endif

  // Arbitration: grants are only possible in IDLE and never while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
        grant0 = ~ptr_q;
        grant1 = ptr_q;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept    = grant0 | grant1;
  assign winner    = grant1;
  assign handshake = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: EXEC lasts exactly one cycle; RESP waits for the owner's handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (handshake) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the winner's payload on accept and capture the ALU result in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sel_q    <= '0;
      src_q    <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= winner ? req1_op  : req0_op;
        sel_q   <= winner ? req1_sel : req0_sel;
        src_q   <= winner ? req1_src : req0_src;
        owner_q <= winner;
      end
      if (state_q == S_EXEC) result_q <= alu_result;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Round-robin pointer: after each accept, prefer the requester that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= 1'b0;
    else if (accept) ptr_q <= ~winner;
  end
`endif

  assign drive_alu = (state_q == S_EXEC) || (IDLE_ZERO == 0);

  // Outputs: handshakes, owner-only response, and the shared ALU drive.
  always_comb begin
    req0_ready  = grant0;
    req1_ready  = grant1;
    rsp0_valid  = (state_q == S_RESP) && !owner_q;
    rsp1_valid  = (state_q == S_RESP) &&  owner_q;
    rsp0_result = rsp0_valid ? result_q : 32'd0;
    rsp1_result = rsp1_valid ? result_q : 32'd0;
    alu_op      = 4'd0;
    d1_sel      = 1'b0;
    d2_sel      = 1'b0;
    rs1_data    = 32'd0;
    rs2_data    = 32'd0;
    immediate   = 32'd0;
    pc          = 32'd0;
    if (drive_alu) begin
      alu_op    = op_q;
      d1_sel    = sel_q[1];
      d2_sel    = sel_q[0];
      rs1_data  = src_q[127:96];
      rs2_data  = src_q[95:64];
      immediate = src_q[63:32];
      pc        = src_q[31:0];
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios followed by random traffic.
// The bench contains its own stand-in ALU.
// It also keeps a transaction-level model of the expected handshakes.
// Two instances share the same stimulus: IDLE_ZERO=1 and IDLE_ZERO=0.
module tb_alu_share_arbiter;

  logic         clk, rst_n;
  logic         req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [1:0]   req0_sel, req1_sel;
  logic [127:0] req0_src, req1_src;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0]  rsp0_result, rsp1_result;
  logic [3:0]   alu_op_z, alu_op_h;
  logic         d1_z, d2_z, d1_h, d2_h;
  logic [31:0]  rs1_z, rs2_z, imm_z, pc_z, rs1_h, rs2_h, imm_h, pc_h;
  logic         req0_ready_h, req1_ready_h, rsp0_valid_h, rsp1_valid_h;
  logic [31:0]  rsp0_result_h, rsp1_result_h;
  logic [31:0]  alu_result;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  int           cyc = 0;
  bit           busy = 0;
  int           acc_cyc = 0;
  int           owner = 0;
  bit           pref = 0;
  logic [31:0]  res_exp = '0;
  logic [135:0] lat = '0;
  logic [135:0] hold_pack = '0;
  bit           acc0 = 0, acc1 = 0;
  int           grants[$];

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return {31'd0, $signed(a) < $signed(b)};
      default: return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
    endcase
  endfunction

  // Expected result straight from a request: d1_sel picks pc over rs1, d2_sel picks immediate over rs2.
  function automatic logic [31:0] exp_res(input logic [3:0] op, input logic [1:0] sel, input logic [127:0] src);
    logic [31:0] a, b;
    a = sel[1] ? src[31:0]  : src[127:96];
    b = sel[0] ? src[63:32] : src[95:64];
    return ref_alu(op, a, b);
  endfunction

  assign alu_result = ref_alu(alu_op_z, d1_z ? pc_z : rs1_z, d2_z ? imm_z : rs2_z);

  alu_share_arbiter #(.IDLE_ZERO(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_sel(req0_sel), .req0_src(req0_src),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_sel(req1_sel), .req1_src(req1_src),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_op(alu_op_z), .d1_sel(d1_z), .d2_sel(d2_z), .rs1_data(rs1_z), .rs2_data(rs2_z),
    .immediate(imm_z), .pc(pc_z), .alu_result(alu_result)
  );

  alu_share_arbiter #(.IDLE_ZERO(0)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_h), .req0_op(req0_op), .req0_sel(req0_sel), .req0_src(req0_src),
    .rsp0_valid(rsp0_valid_h), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result_h),
    .req1_valid(req1_valid), .req1_ready(req1_ready_h), .req1_op(req1_op), .req1_sel(req1_sel), .req1_src(req1_src),
    .rsp1_valid(rsp1_valid_h), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result_h),
    .alu_op(alu_op_h), .d1_sel(d1_h), .d2_sel(d2_h), .rs1_data(rs1_h), .rs2_data(rs2_h),
    .immediate(imm_h), .pc(pc_h), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [135:0] pay_z();
    return {alu_op_z, d1_z, d2_z, rs1_z, rs2_z, imm_z, pc_z};
  endfunction

  function automatic logic [135:0] pay_h();
    return {alu_op_h, d1_h, d2_h, rs1_h, rs2_h, imm_h, pc_h};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {req0_ready, req1_ready, req0_ready_h, req1_ready_h}, 0);
    check({tag, "_rspv"}, {rsp0_valid, rsp1_valid, rsp0_valid_h, rsp1_valid_h}, 0);
    check({tag, "_rsp_z"}, {rsp0_result, rsp1_result}, 0);
    check({tag, "_rsp_h"}, {rsp0_result_h, rsp1_result_h}, 0);
    check({tag, "_alu_z"}, pay_z(), 0);
    check({tag, "_alu_h"}, pay_h(), 0);
  endtask

  task automatic rand_pay(output logic [3:0] op, output logic [1:0] sel, output logic [127:0] src);
    op  = 4'($urandom_range(0, 9));
    sel = 2'($urandom_range(0, 3));
    src = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock cycle.
  // Inputs are already applied; check outputs mid-cycle against the model, then advance.
  task automatic step();
    int w;
    acc0 = 0;
    acc1 = 0;
    #1;
    check("alu_hold", pay_h(), hold_pack);
    if (!busy) begin
      w = -1;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
        w = pref ? 1 : 0;
`else
        w = 0;
`endif
      end else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
      check("req_ready_idle", {req0_ready, req1_ready}, {w == 0, w == 1});
      check("rsp_valid_idle", {rsp0_valid, rsp1_valid}, 0);
      check("rsp_result_idle", {rsp0_result, rsp1_result}, 0);
      check("alu_zero_idle", pay_z(), 0);
      if (w >= 0) begin
        busy    = 1;
        acc_cyc = cyc;
        owner   = w;
        lat     = (w == 1) ? {req1_op, req1_sel, req1_src} : {req0_op, req0_sel, req0_src};
        res_exp = (w == 1) ? exp_res(req1_op, req1_sel, req1_src) : exp_res(req0_op, req0_sel, req0_src);
        pref    = (w == 0);
        grants.push_back(w);
        acc0    = (w == 0);
        acc1    = (w == 1);
        hold_pack = lat;
      end
    end else begin
      check("req_ready_busy", {req0_ready, req1_ready}, 0);
      if (cyc == acc_cyc + 1) begin
        check("rsp_valid_exec", {rsp0_valid, rsp1_valid}, 0);
        check("rsp_result_exec", {rsp0_result, rsp1_result}, 0);
        check("alu_exec", pay_z(), lat);
      end else begin
        check("rsp_valid_resp", {rsp0_valid, rsp1_valid}, (owner == 1) ? 2'b01 : 2'b10);
        check("rsp_result_resp", {rsp0_result, rsp1_result},
              (owner == 1) ? {32'd0, res_exp} : {res_exp, 32'd0});
        check("alu_zero_resp", pay_z(), 0);
        if ((owner == 1) ? rsp1_ready : rsp0_ready) busy = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    for (int i = 0; i < 10 && busy; i++) step();
    check("drain_done", busy, 0);
  endtask

  initial begin
    int exp_g[4];
    rst_n = 0;
    req0_valid = 1; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = 4'd3; req0_sel = 2'b11; req0_src = {4{32'h1234_5678}};
    req1_op = '0; req1_sel = '0; req1_src = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    req0_valid = 0;
    rst_n = 1;

    // Both requesters valid every cycle, responses always consumed: watch grant order.
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    grants.delete();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    rand_pay(req0_op, req0_sel, req0_src);
    rand_pay(req1_op, req1_sel, req1_src);
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      step();
      if (acc0) rand_pay(req0_op, req0_sel, req0_src);
      if (acc1) rand_pay(req1_op, req1_sel, req1_src);
    end
    req0_valid = 0; req1_valid = 0;
    check("grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check($sformatf("grant%0d", i), grants[i], exp_g[i]);
    drain();

    // req0 alone, 5 + 7 -> 12, response two cycles after accept.
    req0_valid = 1; req0_op = 4'd0; req0_sel = 2'b00;
    req0_src = {32'd5, 32'd7, 32'd0, 32'd0};
    rsp0_ready = 1;
    step();
    check("add_accept", acc0, 1);
    req0_valid = 0;
    step();
    #1;
    check("add_rsp_valid", rsp0_valid, 1);
    check("add_rsp_result", rsp0_result, 32'd12);
    step();
    check("add_done", busy, 0);

    // req1 result stalls 5 cycles while req0 waits.
    req1_valid = 1; req1_op = 4'd0; req1_sel = 2'b00;
    req1_src = {32'hDEADBEEF, 32'd0, 32'd0, 32'd0};
    rsp1_ready = 0; rsp0_ready = 1;
    step();
    req1_valid = 0;
    req0_valid = 1; rand_pay(req0_op, req0_sel, req0_src);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_result", rsp1_result, 32'hDEADBEEF);
      check("stall_req0_ready", req0_ready, 0);
      step();
    end
    rsp1_ready = 1;
    step();
    step();
    check("resume_accept0", acc0, 1);
    drain();

    // Reset pulse during EXEC discards the transaction.
    req0_valid = 1; rand_pay(req0_op, req0_sel, req0_src);
    step();
    req0_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check_all_zero("rst_exec");
    #1;
    rst_n = 1;
    busy = 0; pref = 0; hold_pack = '0;
    for (int i = 0; i < 4; i++) step();
    req0_valid = 1; rand_pay(req0_op, req0_sel, req0_src);
    step();
    req0_valid = 0;
    drain();

    // Held operands with IDLE_ZERO=0, zeros with IDLE_ZERO=1.
    req1_valid = 1; req1_op = 4'd0; req1_sel = 2'b10;
    req1_src = {32'd1, 32'd2, 32'h20, 32'h100};
    step();
    req1_valid = 0;
    drain();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_pc_held", pc_h, 32'h100);
      check("idle_zero", {alu_op_z, rs1_z, rs2_z, imm_z, pc_z}, 0);
      step();
    end

    // Random traffic.
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 300; i++) begin
      if (acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        rand_pay(req0_op, req0_sel, req0_src);
      end else if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1;
        rand_pay(req0_op, req0_sel, req0_src);
      end
      if (acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        rand_pay(req1_op, req1_sel, req1_src);
      end else if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1;
        rand_pay(req1_op, req1_sel, req1_src);
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter IDLE_ZERO, default 1: 1 = drive all ALU operand/control outputs to 0 when not in EXEC.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have reqN_ready  output  1  requester N accepted this cycle.
REQ-006 SHALL have reqN_op  input  4  ALU opcode from requester N.
REQ-007 SHALL have reqN_sel  input  2  [1]=d1_sel, [0]=d2_sel from requester N.
REQ-008 SHALL have reqN_src  input  128  {rs1_data, rs2_data, immediate, pc} from requester N.
REQ-009 SHALL have rspN_valid  output  1  result for requester N available.
REQ-010 SHALL have rspN_ready  input  1  requester N consumes result.
REQ-011 SHALL have rspN_result  output  32  result for requester N.
REQ-012 SHALL have alu_op  output  4,  d1_sel / d2_sel  output  1 each,  rs1_data / rs2_data / immediate / pc  output  32 each: drive the shared combinational ALU.
REQ-013 SHALL have alu_result  input  32  shared ALU result.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-015 IDLE: if any reqN_valid, SHALL assert exactly one reqN_ready (combinational, same cycle) for the winner, latch its op/sel/src and owner ID, go to EXEC.
REQ-016 IDLE with no valid request: SHALL stay IDLE, both reqN_ready low.
REQ-017 EXEC (exactly one cycle): SHALL drive ALU outputs from latched registers, capture alu_result into result register at the clock edge, go to RESP.
REQ-018 RESP: SHALL hold rspN_valid high for owner only, rspN_result = captured value, stable until rspN_ready high; on handshake go to IDLE.
REQ-019 Latency: request accepted at edge T SHALL yield rsp valid during cycle T+2; peak throughput one op per 3 cycles.
REQ-020 reqN_ready SHALL be low in EXEC and RESP; requests arriving then wait.
REQ-021 Requesters SHALL hold reqN_valid and payload stable until ready; arbiter SHALL sample payload only on the accept cycle.
REQ-022 rspN_ready low (stall) in RESP SHALL hold state, result and ALU outputs unchanged indefinitely.
REQ-023 rspN_ready for non-owner SHALL be ignored; rspN_result for non-owner SHALL read 0.
REQ-024 Outside EXEC, ALU outputs SHALL be 0 when IDLE_ZERO=1, else hold last latched values.
REQ-025 Arbitration when both valid SHALL follow the Configuration rule; single valid requester always wins.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, all reqN_ready/rspN_valid 0, rspN_result 0, all ALU outputs 0, latched registers 0, priority pointer to requester 0.
REQ-027 Reset mid-EXEC or mid-RESP SHALL discard the transaction; no response issued after release.
REQ-028 First arbitration after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin; 1-bit pointer names preferred requester, flips to the non-winner on each accept.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; pointer logic absent.

Verification
REQ-031 req0 only, op=4'h0, src rs1=5, rs2=7; bench drives alu_result=12 in EXEC -> req0_ready 1 cycle, rsp0_valid at T+2, rsp0_result=12.
REQ-032 Both valid every cycle, 4 ops, rsp ready tied high -> RR_EN: grants 0,1,0,1; without RR_EN: grants 0,0,0,0.
REQ-033 rsp1_ready held low 5 cycles in RESP with result 0xDEADBEEF -> rsp1_valid/result stable 5 cycles, req0_ready stays 0, accept resumes after handshake.
REQ-034 rst_n pulsed low during EXEC -> all outputs 0 immediately, no rsp_valid after release, next request completes normally.
REQ-035 IDLE_ZERO=1, no traffic -> alu_op, rs1_data, rs2_data, immediate, pc all 0; IDLE_ZERO=0 -> last operands (e.g. pc=0x100) held.
